// File: rtl/multicycle_controlpath.sv
// Multi-cycle RV32I-subset control FSM (lw/sw/R/I-ALU/beq/jal) sharing one memory
// port; Moore select decode, memory-ack timeout into a sticky ERROR, retire counter.
module multicycle_controlpath #(
  parameter int ALUCTRL_W   = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16,
  parameter int EN_JAL      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 zero,
  input  logic                 mem_ack,
  input  logic [31:0]          INSTRin,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 MemWrite,
  output logic                 mem_req,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           ImmSrc,
  output logic                 RegWrite,
  output logic                 busy,
  output logic                 illegal,
  output logic [CNT_W-1:0]     instr_count
);
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_ERROR
  } state_e;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               retire, tmo, alu_ok;
  logic [2:0]         alu_dec, alu_sel;
  state_e             after_ret;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5, unused_instr;
  assign opcode       = INSTRin[6:0];
  assign funct3       = INSTRin[14:12];
  assign f7b5         = INSTRin[30];
  assign unused_instr = ^{INSTRin[31], INSTRin[29:15], INSTRin[11:7]};

  // timeout fires on the last allowed no-ack cycle; an ack in that same cycle wins
  assign tmo       = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST);
  assign after_ret = run ? S_FETCH : S_IDLE;
  assign alu_ok    = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);

  always_comb begin
    alu_dec = 3'b000;
    case (funct3)
      3'b000:  alu_dec = (state_q == S_EXECR && f7b5) ? 3'b001 : 3'b000;
      3'b010:  alu_dec = 3'b101;
      3'b110:  alu_dec = 3'b011;
      3'b111:  alu_dec = 3'b010;
      default: alu_dec = 3'b000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ack)  state_d = S_DECODE;
        else if (tmo) state_d = S_ERROR;
        else          wait_d  = wait_q + 1'b1;
      end
      S_DECODE: begin
        case (opcode)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1100011:             state_d = S_BEQ;
          7'b1101111:             state_d = (EN_JAL != 0) ? S_JAL : S_ERROR;
          default:                state_d = S_ERROR;
        endcase
      end
      S_MEMADR: state_d = INSTRin[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_ack)  state_d = S_MEMWB;
        else if (tmo) state_d = S_ERROR;
        else          wait_d  = wait_q + 1'b1;
      end
      S_MEMWRITE: begin
        if (mem_ack) begin
          retire  = 1'b1;
          state_d = after_ret;
        end else if (tmo) state_d = S_ERROR;
        else              wait_d  = wait_q + 1'b1;
      end
      S_MEMWB, S_ALUWB, S_BEQ: begin
        retire  = 1'b1;
        state_d = after_ret;
      end
      S_EXECR, S_EXECI: state_d = alu_ok ? S_ALUWB : S_ERROR;
      S_JAL:            state_d = S_ALUWB;
      S_ERROR:          state_d = S_ERROR;
      default:          state_d = S_ERROR;
    endcase
  end

  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    mem_req   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_sel   = 3'b000;
    ImmSrc    = 2'b00;
    RegWrite  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = INSTRin[5] ? 2'b01 : 2'b00;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_sel = alu_dec;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_sel = alu_dec;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_sel = 3'b001;
        PCWrite = zero;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        ImmSrc  = 2'b11;
      end
      default: ;
    endcase
  end

  assign ALUControl  = ALUCTRL_W'(alu_sel);
  assign busy        = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign illegal     = (state_q == S_ERROR);
  assign instr_count = cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (retire) cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: doc/multicycle_controlpath.md
Name: multicycle_controlpath

Overview:
- Parametrised successor to the single-cycle control path: an FSM that sequences a multi-cycle RV32I subset (lw, sw, R-type, I-type ALU, beq, jal) over one shared memory port.
- Sits beside the datapath. Drives the per-state datapath selects, handshakes with memory through mem_req/mem_ack, and reports errors.
- Counts retired instructions.

Parameters:
- ALUCTRL_W, 3, ALUControl width; must be ≥3, upper bits zero-filled.
- MEM_TIMEOUT, 15, maximum cycles to wait for mem_ack before entering ERROR; 0 disables the timeout.
- CNT_W, 16, width of retired-instruction counter.
- EN_JAL, 1, when 0, jal decodes as illegal.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level; permits fetching new instructions.
- zero  in  1  ALU zero flag from datapath.
- mem_ack  in  1  memory access complete this cycle.
- INSTRin  in  32  instruction register contents; valid from DECODE onward.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
- IRWrite  out  1  instruction register enable.
- MemWrite  out  1  memory write strobe.
- mem_req  out  1  memory access request.
- ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1.
- ALUSrcB  out  2  ALU B select: 00=rs2, 01=imm, 10=const 4.
- ALUControl  out  ALUCTRL_W  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- ImmSrc  out  2  immediate format: 00=I, 01=S, 10=B, 11=J.
- RegWrite  out  1  register file write enable.
- busy  out  1  high in every state except IDLE and ERROR.
- illegal  out  1  sticky error flag.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; all outputs 0, including instr_count and illegal.
  - Reset mid-access drops mem_req and MemWrite immediately.
- Outputs are Moore, decoded from state. Exception: PCWrite in BEQ, which is zero-qualified.
- Don't-care selects are driven 0.
- IDLE:
  - run=1 → FETCH.
- FETCH:
  - Always drives mem_req=1, AdrSrc=0.
  - Wait cycles (no ack): all enables 0.
  - On mem_ack: IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10; next state DECODE.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ImmSrc=10, add (computes branch target).
  - Transition on opcode INSTRin[6:0]:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXECR.
    - 0010011 → EXECI.
    - 1100011 → BEQ.
    - 1101111 (when EN_JAL) → JAL.
    - Otherwise → ERROR.
- MEMADR:
  - ALUSrcA=10, ALUSrcB=01, add.
  - ImmSrc=00 for lw, 01 for sw.
  - → MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD:
  - mem_req=1, AdrSrc=1, ResultSrc=00; hold until mem_ack.
  - On mem_ack → MEMWB.
- MEMWRITE:
  - mem_req=1, MemWrite=1, AdrSrc=1; hold until mem_ack.
  - On mem_ack: retire, → FETCH.
- MEMWB:
  - ResultSrc=01, RegWrite=1; retire.
- EXECR / EXECI:
  - ALUSrcA=10; ALUSrcB=00 (EXECR) or 01 (EXECI, ImmSrc=00).
  - ALU decode from funct3/funct7b5:
    - 000: add; sub only in R-type when funct7b5=1.
    - 010: slt. 110: or. 111: and.
    - Any other funct3 → ERROR instead of ALUWB.
  - → ALUWB.
- ALUWB:
  - ResultSrc=00, RegWrite=1; retire.
- BEQ:
  - ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=zero; retire.
- JAL:
  - ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, ImmSrc=11 → ALUWB.
  - The retire for jal happens in ALUWB.
- Post-retire transition:
  - run=1 → FETCH.
  - run=0 → IDLE.
  - Dropping run never aborts an instruction in flight.
- Retire:
  - instr_count+1, wraps modulo 2^CNT_W.
- Timeout:
  - Per-access wait counter clears on entry to FETCH/MEMREAD/MEMWRITE.
  - If MEM_TIMEOUT>0 and the wait count reaches MEM_TIMEOUT with no ack, go to ERROR.
  - mem_ack on exactly the MEM_TIMEOUT-th wait cycle is accepted; ack has priority.
- ERROR:
  - illegal=1, all enables 0, busy=0.
  - Exits only via reset.
- mem_ack outside request states is ignored.

Test Plan:
- Reset, run=1, mem_ack=1 each request, INSTRin=0x00500093 (addi) → FETCH, DECODE, EXECI, ALUWB. RegWrite=1 in cycle 4; instr_count=1.
- lw 0x0000A103, mem_ack delayed 3 cycles in MEMREAD → mem_req held 4 cycles, AdrSrc=1. MEMWB follows with ResultSrc=01, RegWrite=1. Total 5 + 3 wait cycles.
- beq 0x00208463 with zero=1, then zero=0 → PCWrite=1 in BEQ for the first, 0 for the second. Both increment instr_count.
- sw with mem_ack never asserted, MEM_TIMEOUT=15 → after 15 wait cycles, ERROR: illegal=1, busy=0, MemWrite=0. Stays until reset.
- Opcode 0x7F, and separately jal with EN_JAL=0 → ERROR after DECODE; instr_count unchanged.
- run dropped during EXECR → instruction completes ALUWB, then IDLE. Assert reset during a MEMWRITE wait → MemWrite=0 asynchronously, count=0.
